// File: rtl/vend_credit_fsm.sv
// Vending credit controller: latches a product price, accumulates 5/10 coins,
// dispenses with change, and refunds on cancel or inactivity timeout.
module vend_credit_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       cancel,
    output logic       z_10,
    output logic       z_15,
    output logic       z_20,
    output logic       c1_10,
    output logic       c1_15,
    output logic       c1_20,
    output logic       c2_10,
    output logic       c2_15,
    output logic       c2_20,
    output logic       busy
);

    // state    | meaning
    // IDLE     | waiting for a product select
    // COLLECT  | accumulating coins, timeout counter running
    // DISPENSE | one cycle: product plus change in credit_q
    // REFUND   | one cycle: return everything held in credit_q
    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_REFUND
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    price_q, price_d;
    logic [1:0]    credit_q, credit_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    z_q, z_d;
    logic [2:0]    c1_q, c1_d;
    logic [2:0]    c2_q, c2_d;

    logic [2:0]    add;
    logic [2:0]    sum;
    logic [2:0]    price_u;
    logic [2:0]    grp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            price_q  <= 2'b00;
            credit_q <= 2'b00;
            tmo_q    <= '0;
            z_q      <= 3'b000;
            c1_q     <= 3'b000;
            c2_q     <= 3'b000;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            z_q      <= z_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
        end
    end

    // Credit and price are in units of 5; after payment credit_q holds the change.
    always_comb begin
        state_d  = state_q;
        price_d  = price_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        z_d      = 3'b000;
        c1_d     = 3'b000;
        c2_d     = 3'b000;
        add      = {1'b0, coin10, coin5};
        sum      = {1'b0, credit_q} + add;
        price_u  = {1'b0, price_q} + 3'd1;
        case (price_q)
            2'b01:   grp = 3'b001;
            2'b10:   grp = 3'b010;
            2'b11:   grp = 3'b100;
            default: grp = 3'b000;
        endcase

        case (state_q)
            S_IDLE: begin
                if (sel != 2'b00) begin
                    price_d  = sel;
                    credit_d = 2'b00;
                    tmo_d    = '0;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_d = S_REFUND;
                end else if (coin5 || coin10) begin
                    tmo_d = '0;
                    if (sum >= price_u) begin
                        credit_d = 2'(sum - price_u);
                        state_d  = S_DISPENSE;
                    end else begin
                        credit_d = sum[1:0];
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_REFUND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DISPENSE, S_REFUND: begin
                if (state_q == S_DISPENSE) z_d = grp;
                c1_d    = credit_q[0] ? grp : 3'b000;
                c2_d    = credit_q[1] ? grp : 3'b000;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign {z_20, z_15, z_10}    = z_q;
    assign {c1_20, c1_15, c1_10} = c1_q;
    assign {c2_20, c2_15, c2_10} = c2_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: directed vector table, hand-written timeout/reset
// sequences, and random traffic against a money-level reference model.
module tb_vend_credit_fsm;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] sel = 2'b00;
    logic coin5 = 1'b0, coin10 = 1'b0, cancel = 1'b0;
    logic z_10, z_15, z_20, c1_10, c1_15, c1_20, c2_10, c2_15, c2_20, busy;

    int n_checks = 0;
    int n_errors = 0;

    vend_credit_fsm #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .coin5(coin5), .coin10(coin10),
        .cancel(cancel), .z_10(z_10), .z_15(z_15), .z_20(z_20),
        .c1_10(c1_10), .c1_15(c1_15), .c1_20(c1_20),
        .c2_10(c2_10), .c2_15(c2_15), .c2_20(c2_20), .busy(busy)
    );

    always #5 clk = ~clk;

    // {z20,z15,z10, c1_20,c1_15,c1_10, c2_20,c2_15,c2_20..c2_10, busy}
    function automatic logic [9:0] pack(input logic [2:0] z, input logic [2:0] c1,
                                        input logic [2:0] c2, input logic b);
        return {z, c1, c2, b};
    endfunction

    function automatic logic [9:0] actual();
        return {z_20, z_15, z_10, c1_20, c1_15, c1_10, c2_20, c2_15, c2_10, busy};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got z=%b c1=%b c2=%b busy=%b, expected z=%b c1=%b c2=%b busy=%b",
                     name, act[9:7], act[6:4], act[3:1], act[0],
                     exp[9:7], exp[6:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic c5, input logic c10, input logic can);
        sel = s; coin5 = c5; coin10 = c10; cancel = can;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       c5, c10, can;
        logic [2:0] z, c1, c2;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    // Reference model: money in currency units, transaction flags.
    int  m_price, m_money, m_idle, m_amt;
    bit  m_collect, m_settle, m_disp;
    logic [9:0] m_exp;

    task automatic model_reset();
        m_price = 0; m_money = 0; m_idle = 0; m_amt = 0;
        m_collect = 0; m_settle = 0; m_disp = 0;
    endtask

    task automatic model_edge(input logic [1:0] s, input logic c5, input logic c10, input logic can);
        logic [2:0] z, c1, c2;
        int g;
        z = 0; c1 = 0; c2 = 0;
        if (m_settle) begin
            g = m_price / 5 - 2;
            if (m_disp) z[g] = 1'b1;
            if (m_amt % 10 == 5) c1[g] = 1'b1;
            if (m_amt >= 10) c2[g] = 1'b1;
            m_settle = 0;
        end else if (!m_collect) begin
            if (s != 2'b00) begin
                m_price = 5 + 5 * int'(s);
                m_money = 0; m_idle = 0; m_collect = 1;
            end
        end else if (can) begin
            m_collect = 0; m_settle = 1; m_disp = 0; m_amt = m_money;
        end else if (c5 || c10) begin
            m_money += (c5 ? 5 : 0) + (c10 ? 10 : 0);
            m_idle = 0;
            if (m_money >= m_price) begin
                m_collect = 0; m_settle = 1; m_disp = 1; m_amt = m_money - m_price;
            end
        end else if (m_idle == TMO - 1) begin
            m_collect = 0; m_settle = 1; m_disp = 0; m_amt = m_money;
        end else begin
            m_idle++;
        end
        m_exp = pack(z, c1, c2, m_collect || m_settle);
    endtask

    initial begin
        // exact payment, price 15
        vq.push_back('{2'b10, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0});
        vq.push_back('{2'b00, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0});
        // overpayment, price 10, change 10
        vq.push_back('{2'b01, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 0, 0, 3'b001, 3'b000, 3'b001, 0});
        vq.push_back('{2'b00, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0});
        // cancel with coin in the same cycle, price 20, refund 15
        vq.push_back('{2'b11, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 1, 1, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 0, 0, 3'b000, 3'b100, 3'b100, 0});
        vq.push_back('{2'b00, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0});
        // sel ignored in COLLECT, coins ignored in DISPENSE/IDLE, fresh credit next time
        vq.push_back('{2'b11, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b01, 0, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b01, 0, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 1, 1, 3'b100, 3'b000, 3'b000, 0});
        vq.push_back('{2'b00, 0, 1, 0, 3'b000, 3'b000, 3'b000, 0});
        vq.push_back('{2'b10, 0, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 1, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 1, 0, 0, 3'b000, 3'b000, 3'b000, 1});
        vq.push_back('{2'b00, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0});
        vq.push_back('{2'b00, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0});

        #2;
        check("reset_state", actual(), pack(3'b000, 3'b000, 3'b000, 1'b0));
        #10 rst_n = 1'b1;
        @(negedge clk);

        foreach (vq[i]) begin
            drive(vq[i].sel, vq[i].c5, vq[i].c10, vq[i].can);
            step();
            check($sformatf("vec%0d", i), actual(),
                  pack(vq[i].z, vq[i].c1, vq[i].c2, vq[i].busy));
        end

        // timeout: price 10, one coin5, then TMO idle cycles
        drive(2'b01, 0, 0, 0); step();
        drive(2'b00, 1, 0, 0); step();
        drive(2'b00, 0, 0, 0);
        for (int i = 0; i < TMO; i++) begin
            step();
            check($sformatf("tmo_wait%0d", i), actual(), pack(3'b000, 3'b000, 3'b000, 1'b1));
        end
        step();
        check("tmo_refund", actual(), pack(3'b000, 3'b001, 3'b000, 1'b0));
        step();
        check("tmo_after", actual(), pack(3'b000, 3'b000, 3'b000, 1'b0));

        // reset mid-transaction: price 20 with credit 10
        drive(2'b11, 0, 0, 0); step();
        drive(2'b00, 0, 1, 0); step();
        drive(2'b00, 0, 0, 0);
        check("pre_reset_busy", actual(), pack(3'b000, 3'b000, 3'b000, 1'b1));
        #2 rst_n = 1'b0;
        #1 check("reset_async", actual(), pack(3'b000, 3'b000, 3'b000, 1'b0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_reset%0d", i), actual(), pack(3'b000, 3'b000, 3'b000, 1'b0));
        end

        // random traffic against the reference model, starting from a fresh reset
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] s;
            logic c5, c10, can;
            s   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            c5  = ($urandom_range(0, 2) == 0);
            c10 = ($urandom_range(0, 2) == 0);
            can = ($urandom_range(0, 15) == 0);
            drive(s, c5, c10, can);
            model_edge(s, c5, c10, can);
            step();
            check($sformatf("rand%0d", i), actual(), m_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
